// File: rtl/fas.sv
`default_nettype none
// ============================================================================
// Module   : fas
// Brief    : 32-tap symmetric FIR -> 16-point running DFT -> dominant-bin pick
// Revision : 1.0 - initial release
// ============================================================================
module fas (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid,
    input  logic [15:0] data,
    output logic        fir_valid,
    output logic [15:0] fir_d,
    output logic        fft_valid,
    output logic [31:0] fft_d0,
    output logic [31:0] fft_d1,
    output logic [31:0] fft_d2,
    output logic [31:0] fft_d3,
    output logic [31:0] fft_d4,
    output logic [31:0] fft_d5,
    output logic [31:0] fft_d6,
    output logic [31:0] fft_d7,
    output logic [31:0] fft_d8,
    output logic [31:0] fft_d9,
    output logic [31:0] fft_d10,
    output logic [31:0] fft_d11,
    output logic [31:0] fft_d12,
    output logic [31:0] fft_d13,
    output logic [31:0] fft_d14,
    output logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq
);
    localparam logic signed [19:0] c_coef [16] = '{
        20'shFFF9E, 20'shFFF86, 20'shFFFA7, 20'sh0003B,
        20'sh0014B, 20'sh0024A, 20'sh00222, 20'shFFFE4,
        20'shFFBC5, 20'shFF7CA, 20'shFF74E, 20'shFFD74,
        20'sh00B1A, 20'sh01DAC, 20'sh02F9E, 20'sh03AA9
    };
    // First-quadrant cosine magnitudes; the rest of the circle is sign/index folding.
    localparam logic signed [17:0] c_cos [4] = '{
        18'sd65536, 18'sd60547, 18'sd46341, 18'sd25080
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [4:0]         r_fill;
    logic               w_fire;
    logic signed [15:0] r_taps [31];
    logic signed [15:0] w_win [32];
    logic signed [36:0] w_prod [16];
    logic signed [43:0] w_fir_sum;
    logic               r_fir_valid;
    logic signed [15:0] r_fir_d;
    logic               w_unused_fir;

    // The incoming sample completes the 32-sample window in the capture cycle.
    assign w_win[0] = data;
    generate
        for (genvar i = 1; i < 32; i++) begin : g_win
            assign w_win[i] = r_taps[i-1];
        end
        for (genvar i = 0; i < 16; i++) begin : g_tap
            logic signed [16:0] w_pair;
            assign w_pair    = 17'(w_win[i]) + 17'(w_win[31-i]);
            assign w_prod[i] = 37'(w_pair) * 37'(c_coef[i]);
        end
    endgenerate

    always_comb begin
        w_fir_sum = '0;
        for (int i = 0; i < 16; i++) begin
            w_fir_sum = w_fir_sum + 44'(w_prod[i]);
        end
    end

    assign w_unused_fir = ^{w_fir_sum[43:32], w_fir_sum[15:0]};

    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_valid && (r_fill == 5'd31)) begin
                    w_state_next = S_RUN;
                    w_fire       = 1'b1;
                end
            end
            S_RUN:   w_fire = data_valid;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fill      <= '0;
            r_fir_valid <= 1'b0;
            r_fir_d     <= '0;
            for (int i = 0; i < 31; i++) r_taps[i] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_fir_valid <= w_fire;
            if (data_valid) begin
                r_taps[0] <= data;
                for (int i = 1; i < 31; i++) r_taps[i] <= r_taps[i-1];
                if (r_state == S_IDLE) r_fill <= r_fill + 5'd1;
            end
            if (w_fire) r_fir_d <= w_fir_sum[31:16];
        end
    end

    // Running DFT: each FIR sample is folded into all 16 bins as it arrives.
    function automatic logic signed [33:0] f_cos_term(
        input logic [3:0]         m,
        input logic signed [33:0] p0,
        input logic signed [33:0] p1,
        input logic signed [33:0] p2,
        input logic signed [33:0] p3
    );
        case (m)
            4'd0:    f_cos_term = p0;
            4'd1:    f_cos_term = p1;
            4'd2:    f_cos_term = p2;
            4'd3:    f_cos_term = p3;
            4'd5:    f_cos_term = -p3;
            4'd6:    f_cos_term = -p2;
            4'd7:    f_cos_term = -p1;
            4'd8:    f_cos_term = -p0;
            4'd9:    f_cos_term = -p1;
            4'd10:   f_cos_term = -p2;
            4'd11:   f_cos_term = -p3;
            4'd13:   f_cos_term = p3;
            4'd14:   f_cos_term = p2;
            4'd15:   f_cos_term = p1;
            default: f_cos_term = '0;
        endcase
    endfunction

    logic [3:0]         r_n;
    logic               r_fft_valid;
    logic signed [33:0] w_tp [4];
    logic signed [39:0] r_acc_re [16];
    logic signed [39:0] r_acc_im [16];
    logic signed [39:0] w_re_next [16];
    logic signed [39:0] w_im_next [16];
    logic signed [15:0] r_fft_re [16];
    logic signed [15:0] r_fft_im [16];

    generate
        for (genvar j = 0; j < 4; j++) begin : g_tw
            assign w_tp[j] = 34'(r_fir_d) * 34'(c_cos[j]);
        end
        for (genvar k = 0; k < 16; k++) begin : g_bin
            logic [3:0]         w_m;
            logic signed [39:0] w_re_base;
            logic signed [39:0] w_im_base;
            assign w_m       = r_n * 4'(k);
            assign w_re_base = (r_n == 4'd0) ? 40'sd0 : r_acc_re[k];
            assign w_im_base = (r_n == 4'd0) ? 40'sd0 : r_acc_im[k];
            // sin(m) == cos(m - 4); the imaginary twiddle term is -sin.
            assign w_re_next[k] = w_re_base
                + 40'(f_cos_term(w_m, w_tp[0], w_tp[1], w_tp[2], w_tp[3]));
            assign w_im_next[k] = w_im_base
                - 40'(f_cos_term(w_m + 4'd12, w_tp[0], w_tp[1], w_tp[2], w_tp[3]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= '0;
            r_fft_valid <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                r_acc_re[k] <= '0;
                r_acc_im[k] <= '0;
                r_fft_re[k] <= '0;
                r_fft_im[k] <= '0;
            end
        end else begin
            r_fft_valid <= 1'b0;
            if (r_fir_valid) begin
                r_n <= r_n + 4'd1;
                for (int k = 0; k < 16; k++) begin
                    r_acc_re[k] <= w_re_next[k];
                    r_acc_im[k] <= w_im_next[k];
                end
                if (r_n == 4'd15) begin
                    r_fft_valid <= 1'b1;
                    for (int k = 0; k < 16; k++) begin
                        r_fft_re[k] <= w_re_next[k][31:16];
                        r_fft_im[k] <= w_im_next[k][31:16];
                    end
                end
            end
        end
    end

    // Peak search: one bin per cycle, bin 0 is evaluated in the fft_valid cycle.
    logic               r_scan;
    logic [3:0]         r_scan_k;
    logic [3:0]         r_best_k;
    logic [32:0]        r_best_p;
    logic               r_done;
    logic [3:0]         r_freq;
    logic [3:0]         w_idx;
    logic signed [15:0] w_sel_re;
    logic signed [15:0] w_sel_im;
    logic signed [31:0] w_sq_re;
    logic signed [31:0] w_sq_im;
    logic [32:0]        w_p;

    assign w_idx    = r_scan ? r_scan_k : 4'd0;
    assign w_sel_re = r_fft_re[w_idx];
    assign w_sel_im = r_fft_im[w_idx];
    assign w_sq_re  = 32'(w_sel_re) * 32'(w_sel_re);
    assign w_sq_im  = 32'(w_sel_im) * 32'(w_sel_im);
    assign w_p      = {1'b0, w_sq_re} + {1'b0, w_sq_im};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan   <= 1'b0;
            r_scan_k <= '0;
            r_best_k <= '0;
            r_best_p <= '0;
            r_done   <= 1'b0;
            r_freq   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_fft_valid) begin
                r_scan   <= 1'b1;
                r_scan_k <= 4'd1;
                r_best_p <= w_p;
                r_best_k <= 4'd0;
            end else if (r_scan) begin
                if (w_p > r_best_p) begin
                    r_best_p <= w_p;
                    r_best_k <= r_scan_k;
                end
                r_scan_k <= r_scan_k + 4'd1;
                if (r_scan_k == 4'd15) begin
                    r_scan <= 1'b0;
                    r_done <= 1'b1;
                    r_freq <= (w_p > r_best_p) ? r_scan_k : r_best_k;
                end
            end
        end
    end

    assign fir_valid = r_fir_valid;
    assign fir_d     = r_fir_d;
    assign fft_valid = r_fft_valid;
    assign done      = r_done;
    assign freq      = r_freq;
    assign fft_d0    = {r_fft_re[0],  r_fft_im[0]};
    assign fft_d1    = {r_fft_re[1],  r_fft_im[1]};
    assign fft_d2    = {r_fft_re[2],  r_fft_im[2]};
    assign fft_d3    = {r_fft_re[3],  r_fft_im[3]};
    assign fft_d4    = {r_fft_re[4],  r_fft_im[4]};
    assign fft_d5    = {r_fft_re[5],  r_fft_im[5]};
    assign fft_d6    = {r_fft_re[6],  r_fft_im[6]};
    assign fft_d7    = {r_fft_re[7],  r_fft_im[7]};
    assign fft_d8    = {r_fft_re[8],  r_fft_im[8]};
    assign fft_d9    = {r_fft_re[9],  r_fft_im[9]};
    assign fft_d10   = {r_fft_re[10], r_fft_im[10]};
    assign fft_d11   = {r_fft_re[11], r_fft_im[11]};
    assign fft_d12   = {r_fft_re[12], r_fft_im[12]};
    assign fft_d13   = {r_fft_re[13], r_fft_im[13]};
    assign fft_d14   = {r_fft_re[14], r_fft_im[14]};
    assign fft_d15   = {r_fft_re[15], r_fft_im[15]};

endmodule
`default_nettype wire

// File: tb/tb_fas.sv
`default_nettype none
// ============================================================================
// Module   : tb_fas
// Brief    : scoreboard bench for fas against an arithmetic FIR/DFT model
// Revision : 1.0 - initial release
// ============================================================================
module tb_fas;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [15:0] data;
    logic        fir_valid;
    logic [15:0] fir_d;
    logic        fft_valid;
    logic [31:0] fft_d [16];
    logic        done;
    logic [3:0]  freq;

    fas u_dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .fir_valid(fir_valid), .fir_d(fir_d), .fft_valid(fft_valid),
        .fft_d0(fft_d[0]),   .fft_d1(fft_d[1]),   .fft_d2(fft_d[2]),   .fft_d3(fft_d[3]),
        .fft_d4(fft_d[4]),   .fft_d5(fft_d[5]),   .fft_d6(fft_d[6]),   .fft_d7(fft_d[7]),
        .fft_d8(fft_d[8]),   .fft_d9(fft_d[9]),   .fft_d10(fft_d[10]), .fft_d11(fft_d[11]),
        .fft_d12(fft_d[12]), .fft_d13(fft_d[13]), .fft_d14(fft_d[14]), .fft_d15(fft_d[15]),
        .done(done), .freq(freq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]  q_fir  [$];
    logic [511:0] q_fft  [$];
    logic [3:0]   q_freq [$];

    int hist  [$];
    int frame [$];
    int n_seen;
    int coef [32];
    logic [19:0] c_hex [16] = '{
        20'hFFF9E, 20'hFFF86, 20'hFFFA7, 20'h0003B, 20'h0014B, 20'h0024A, 20'h00222, 20'hFFFE4,
        20'hFFBC5, 20'hFF7CA, 20'hFF74E, 20'hFFD74, 20'h00B1A, 20'h01DAC, 20'h02F9E, 20'h03AA9
    };
    int cos_t [16] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547,
                       -65536, -60547, -46341, -25080, 0, 25080, 46341, 60547};
    int sin_t [16] = '{0, 25080, 46341, 60547, 65536, 60547, 46341, 25080,
                       0, -25080, -46341, -60547, -65536, -60547, -46341, -25080};
    int sine_in [16] = '{512, 473, 362, 196, 0, -196, -362, -473,
                         -512, -473, -362, -196, 0, 196, 362, 473};

    task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        frame.delete();
        n_seen = 0;
        q_fir.delete();
        q_fft.delete();
        q_freq.delete();
    endfunction

    // y[n] = floor(sum C[i]*x[n-i] / 2^16); frames of 16 outputs go through a direct DFT.
    function automatic void model_push(input int x);
        longint       acc, re, im, p, best;
        int           y, bk;
        logic [15:0]  r16, i16;
        logic [511:0] pk;
        hist.push_back(x);
        if (hist.size() > 32) void'(hist.pop_front());
        n_seen++;
        if (n_seen < 32) return;
        acc = 0;
        for (int i = 0; i < 32; i++) acc += longint'(coef[i]) * longint'(hist[31-i]);
        y = int'(acc >>> 16);
        r16 = y[15:0];
        q_fir.push_back(r16);
        frame.push_back(int'($signed(r16)));
        if (frame.size() == 16) begin
            best = -1;
            bk   = 0;
            pk   = '0;
            for (int k = 0; k < 16; k++) begin
                re = 0;
                im = 0;
                for (int n = 0; n < 16; n++) begin
                    re += longint'(frame[n]) * longint'(cos_t[(n*k) % 16]);
                    im -= longint'(frame[n]) * longint'(sin_t[(n*k) % 16]);
                end
                r16 = 16'(re >>> 16);
                i16 = 16'(im >>> 16);
                pk[k*32 +: 32] = {r16, i16};
                p = longint'($signed(r16)) * longint'($signed(r16))
                  + longint'($signed(i16)) * longint'($signed(i16));
                if (p > best) begin
                    best = p;
                    bk   = k;
                end
            end
            q_fft.push_back(pk);
            q_freq.push_back(bk[3:0]);
            frame.delete();
        end
    endfunction

    int          cyc = 0;
    int          cnt_fir, cnt_fft, cnt_done;
    int          last_fft;
    bit          sustain;
    logic [3:0]  last_freq;
    logic [15:0]  m_fir;
    logic [511:0] m_fft;
    logic [3:0]   m_freq;
    logic signed [15:0] m_dr, m_di, m_d;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fir_valid) begin
            cnt_fir++;
            if (q_fir.size() == 0) begin
                chk("fir_unexpected_pulse", q_fir.size() != 0, fir_d, 0);
            end else begin
                m_fir = q_fir.pop_front();
                m_d   = $signed(fir_d - m_fir);
                chk("fir_d", (m_d >= -1) && (m_d <= 1), fir_d, m_fir);
            end
        end
        if (fft_valid) begin
            cnt_fft++;
            if (sustain && (last_fft >= 0))
                chk("fft_spacing", (cyc - last_fft) == 16, cyc - last_fft, 16);
            last_fft = cyc;
            if (q_fft.size() == 0) begin
                chk("fft_unexpected_pulse", q_fft.size() != 0, fft_d[0], 0);
            end else begin
                m_fft = q_fft.pop_front();
                for (int k = 0; k < 16; k++) begin
                    m_dr = $signed(fft_d[k][31:16] - m_fft[k*32+16 +: 16]);
                    m_di = $signed(fft_d[k][15:0]  - m_fft[k*32    +: 16]);
                    chk($sformatf("fft_d%0d", k),
                        (m_dr >= -3) && (m_dr <= 3) && (m_di >= -3) && (m_di <= 3),
                        fft_d[k], m_fft[k*32 +: 32]);
                end
            end
        end
        if (done) begin
            cnt_done++;
            last_freq = freq;
            if (q_freq.size() == 0) begin
                chk("done_unexpected_pulse", q_freq.size() != 0, freq, 0);
            end else begin
                m_freq = q_freq.pop_front();
                chk("freq", freq == m_freq, freq, m_freq);
            end
        end
    end

    task automatic drive(input logic [15:0] x);
        data       = x;
        data_valid = 1'b1;
        @(posedge clk);
        model_push(int'($signed(x)));
        #1;
    endtask

    task automatic idle();
        data_valid = 1'b0;
        data       = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cnt_fir  = 0;
        cnt_fft  = 0;
        cnt_done = 0;
    endtask

    task automatic do_reset();
        bit any;
        data_valid = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        any = fir_valid | fft_valid | done | (|fir_d) | (|freq);
        for (int k = 0; k < 16; k++) any |= |fft_d[k];
        chk("reset_outputs_zero", !any, 32'(any), 0);
        model_reset();
        clear_counts();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            coef[i]    = (c_hex[i] >= 20'h80000) ? int'(c_hex[i]) - (1 << 20) : int'(c_hex[i]);
            coef[31-i] = coef[i];
        end
        rst = 1'b1; data_valid = 1'b0; data = '0;
        clear_counts();
        last_fft = -1; sustain = 1'b0; last_freq = '0;
        model_reset();

        // Reset, then idle input must never raise a valid.
        do_reset();
        repeat (40) idle();
        chk("quiet_no_pulses", (cnt_fir + cnt_fft + cnt_done) == 0, cnt_fir + cnt_fft + cnt_done, 0);

        // DC input.
        do_reset();
        for (int i = 0; i < 31; i++) drive(16'h0100);
        chk("fill_no_fir_valid", fir_valid == 1'b0, fir_valid, 0);
        drive(16'h0100);
        chk("first_fir_valid", fir_valid == 1'b1, fir_valid, 1);
        m_d = $signed(fir_d - 16'h00FF);
        chk("dc_fir_value", (m_d >= -1) && (m_d <= 1), fir_d, 16'h00FF);
        for (int i = 0; i < 63; i++) drive(16'h0100);
        repeat (40) idle();
        chk("dc_frames", cnt_fft == 4, cnt_fft, 4);
        chk("dc_freq", last_freq == 4'd0, last_freq, 0);

        // Impulse.
        do_reset();
        for (int i = 0; i < 31; i++) drive(16'h0000);
        drive(16'h7F00);
        for (int i = 0; i < 63; i++) drive(16'h0000);
        repeat (40) idle();
        chk("impulse_fir_count", cnt_fir == 64, cnt_fir, 64);

        // Bin-1 sinusoid.
        do_reset();
        for (int i = 0; i < 95; i++) drive(16'(sine_in[i % 16]));
        repeat (40) idle();
        chk("sine_done_count", cnt_done == 4, cnt_done, 4);
        chk("sine_freq", (last_freq == 4'd1) || (last_freq == 4'd15), last_freq, 1);

        // Random data with gaps in data_valid.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle();
            else drive(16'($urandom));
        end
        repeat (40) idle();

        // Sustained random stream: 1024 FIR outputs after the fill.
        do_reset();
        sustain  = 1'b1;
        last_fft = -1;
        for (int i = 0; i < 1055; i++) drive(16'($urandom));
        repeat (40) idle();
        sustain = 1'b0;
        chk("stream_fir_count", cnt_fir == 1024, cnt_fir, 1024);
        chk("stream_fft_count", cnt_fft == 64, cnt_fft, 64);
        chk("stream_done_count", cnt_done == 64, cnt_done, 64);

        // Reset in the middle of a frame restarts the fill.
        do_reset();
        for (int i = 0; i < 51; i++) drive(16'($urandom));
        do_reset();
        for (int i = 0; i < 31; i++) drive(16'($urandom));
        chk("refill_no_fir_valid", fir_valid == 1'b0, fir_valid, 0);
        for (int i = 0; i < 17; i++) drive(16'($urandom));
        repeat (40) idle();
        chk("refill_fir_count", cnt_fir == 17, cnt_fir, 17);
        chk("refill_fft_count", cnt_fft == 1, cnt_fft, 1);
        chk("refill_done_count", cnt_done == 1, cnt_done, 1);
        chk("scoreboard_drained", (q_fft.size() + q_freq.size()) == 0, q_fft.size() + q_freq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
